// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph blitter: glyph codes, font geometry,
// FSM state encoding and the font bitmap lookup used to build the glyph ROM.
package glyph_pkg;

   localparam int GLYPH_W   = 8;
   localparam int GLYPH_H   = 16;
   localparam int FB_ADDR_W = 15;
   localparam int PIX_W     = 8;

   typedef enum logic [2:0] {
      GLYPH_G     = 3'd0,
      GLYPH_A     = 3'd1,
      GLYPH_M     = 3'd2,
      GLYPH_E     = 3'd3,
      GLYPH_O     = 3'd4,
      GLYPH_V     = 3'd5,
      GLYPH_R     = 3'd6,
      GLYPH_BLANK = 3'd7
   } glyph_code_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } blit_state_t;

   // Visible rows 2..11 of each glyph, row 2 in the top byte.
   localparam logic [79:0] FONT_G = 80'h3C42_4040_4E42_4246_3A00;
   localparam logic [79:0] FONT_A = 80'h1028_4444_7C44_4444_4400;
   localparam logic [79:0] FONT_M = 80'h4266_5A42_4242_4242_4200;
   localparam logic [79:0] FONT_E = 80'h7E40_4040_7C40_4040_7E00;
   localparam logic [79:0] FONT_O = 80'h3C42_4242_4242_4242_3C00;
   localparam logic [79:0] FONT_V = 80'h4242_4242_4242_2424_1800;
   localparam logic [79:0] FONT_R = 80'h7C42_4242_7C48_4442_4200;

   function automatic logic [7:0] glyph_row_bits(input logic [2:0] code,
                                                 input logic [3:0] row);
      logic [79:0] rows;
      logic [6:0]  sel;
      case (glyph_code_t'(code))
         GLYPH_G: rows = FONT_G;
         GLYPH_A: rows = FONT_A;
         GLYPH_M: rows = FONT_M;
         GLYPH_E: rows = FONT_E;
         GLYPH_O: rows = FONT_O;
         GLYPH_V: rows = FONT_V;
         GLYPH_R: rows = FONT_R;
         default: rows = '0;
      endcase
      if (row < 4'd2 || row > 4'd11) begin
         return 8'h00;
      end
      sel = 7'(8 * (11 - int'(row)));
      return rows[sel +: 8];
   endfunction

endpackage

// File: rtl/glyph_blitter_if.sv
// Framebuffer write port: one pixel per beat, accepted on fb_we & fb_ready.
interface glyph_blitter_if;
   import glyph_pkg::*;

   logic [FB_ADDR_W-1:0] fb_addr;
   logic [PIX_W-1:0]     fb_wdata;
   logic                 fb_we;
   logic                 fb_ready;

   modport master (output fb_addr, output fb_wdata, output fb_we, input fb_ready);
   modport slave  (input fb_addr, input fb_wdata, input fb_we, output fb_ready);

endinterface

// File: rtl/glyph_rom.sv
// 128x8 glyph bitmap ROM addressed by {code, row}, one-cycle registered read.
module glyph_rom
   import glyph_pkg::*;
(
   input  logic       clk,
   input  logic [6:0] addr,
   output logic [7:0] data
);

   logic [7:0] rom_mem [128];
   logic [7:0] data_reg;

   generate
      for (genvar gi = 0; gi < 128; gi++) begin : g_rom
         localparam logic [6:0] ENTRY = 7'(gi);
         assign rom_mem[gi] = glyph_row_bits(ENTRY[6:4], ENTRY[3:0]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      data_reg <= rom_mem[addr];
   end

   assign data = data_reg;

endmodule

// File: rtl/glyph_blitter.sv
// Draws a string of 8x16 glyphs into a framebuffer, one pixel slot per cycle,
// with clipping at the framebuffer edge and write backpressure.
module glyph_blitter
   import glyph_pkg::*;
#(
   parameter int FB_WIDTH  = 160,
   parameter int FB_HEIGHT = 120,
   parameter int MAX_CHARS = 10
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [3:0]             str_len,
   input  logic [3*MAX_CHARS-1:0] char_codes,
   input  logic [7:0]             org_x,
   input  logic [6:0]             org_y,
   input  logic [7:0]             fg_color,
   input  logic                   transparent,
   glyph_blitter_if.master        fb,
   output logic                   busy,
   output logic                   done
);

   blit_state_t            state_reg;
   logic [3:0]             len_reg;
   logic [3*MAX_CHARS-1:0] codes_reg;
   logic [7:0]             org_x_reg;
   logic [6:0]             org_y_reg;
   logic [7:0]             fg_reg;
   logic                   transparent_reg;
   logic [3:0]             char_idx_reg;
   logic [3:0]             row_reg;
   logic [2:0]             col_reg;
   logic [7:0]             slice_reg;
   logic [FB_ADDR_W-1:0]   fb_addr_reg;
   logic [PIX_W-1:0]       fb_wdata_reg;
   logic                   fb_we_reg;
   logic                   busy_reg;
   logic                   done_reg;

   logic [2:0] code_arr [MAX_CHARS];
   logic [2:0] cur_code;
   logic [7:0] rom_data;
   logic [3:0] len_clamped;

   generate
      for (genvar gi = 0; gi < MAX_CHARS; gi++) begin : g_codes
         assign code_arr[gi] = codes_reg[3*gi +: 3];
      end
   endgenerate

   assign cur_code    = code_arr[char_idx_reg];
   assign len_clamped = (str_len > 4'(MAX_CHARS)) ? 4'(MAX_CHARS) : str_len;

   glyph_rom u_rom (
      .clk  (clk),
      .addr ({cur_code, row_reg}),
      .data (rom_data)
   );

   // Next pixel slot: column 0 straight from the ROM when leaving WAIT,
   // otherwise the following column of the latched row slice.
   logic [2:0]  px_col;
   logic [7:0]  px_slice;
   logic        px_bit;
   logic [10:0] px_x;
   logic [9:0]  px_y;
   logic        px_in;
   logic        px_we;
   logic [19:0] px_lin;
   logic [FB_ADDR_W-1:0] px_addr;
   logic [PIX_W-1:0]     px_wdata;

   always_comb begin
      px_col   = 3'(col_reg + 3'd1);
      px_slice = slice_reg;
      if (state_reg == WAIT) begin
         px_col   = 3'd0;
         px_slice = rom_data;
      end
      px_bit   = px_slice[3'd7 - px_col];
      px_x     = 11'(org_x_reg) + 11'({char_idx_reg, 3'b000}) + 11'(px_col);
      px_y     = 10'(org_y_reg) + 10'(row_reg);
      px_in    = (px_x < 11'(FB_WIDTH)) && (px_y < 10'(FB_HEIGHT));
      px_we    = px_in && (px_bit || !transparent_reg);
      px_lin   = 20'(px_y) * 20'(FB_WIDTH) + 20'(px_x);
      px_addr  = px_lin[FB_ADDR_W-1:0];
      px_wdata = px_bit ? fg_reg : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         len_reg         <= '0;
         codes_reg       <= '0;
         org_x_reg       <= '0;
         org_y_reg       <= '0;
         fg_reg          <= '0;
         transparent_reg <= 1'b0;
         char_idx_reg    <= '0;
         row_reg         <= '0;
         col_reg         <= '0;
         slice_reg       <= '0;
         fb_addr_reg     <= '0;
         fb_wdata_reg    <= '0;
         fb_we_reg       <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg  <= 1'b0;
               fb_we_reg <= 1'b0;
               if (start) begin
                  len_reg         <= len_clamped;
                  codes_reg       <= char_codes;
                  org_x_reg       <= org_x;
                  org_y_reg       <= org_y;
                  fg_reg          <= fg_color;
                  transparent_reg <= transparent;
                  char_idx_reg    <= '0;
                  row_reg         <= '0;
                  col_reg         <= '0;
                  if (str_len == 4'd0) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= FETCH;
                     busy_reg  <= 1'b1;
                  end
               end
            end
            FETCH: begin
               state_reg <= WAIT;
            end
            WAIT: begin
               slice_reg    <= rom_data;
               col_reg      <= '0;
               fb_we_reg    <= px_we;
               fb_addr_reg  <= px_addr;
               fb_wdata_reg <= px_wdata;
               state_reg    <= WRITE;
            end
            WRITE: begin
               if (!fb_we_reg || fb.fb_ready) begin
                  if (col_reg != 3'(GLYPH_W - 1)) begin
                     col_reg      <= 3'(col_reg + 3'd1);
                     fb_we_reg    <= px_we;
                     fb_addr_reg  <= px_addr;
                     fb_wdata_reg <= px_wdata;
                  end else begin
                     fb_we_reg <= 1'b0;
                     col_reg   <= '0;
                     if (row_reg != 4'(GLYPH_H - 1)) begin
                        row_reg   <= 4'(row_reg + 4'd1);
                        state_reg <= FETCH;
                     end else if (4'(char_idx_reg + 4'd1) < len_reg) begin
                        char_idx_reg <= 4'(char_idx_reg + 4'd1);
                        row_reg      <= '0;
                        state_reg    <= FETCH;
                     end else begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               fb_we_reg <= 1'b0;
            end
         endcase
      end
   end

   assign fb.fb_addr  = fb_addr_reg;
   assign fb.fb_wdata = fb_wdata_reg;
   assign fb.fb_we    = fb_we_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;

endmodule

// File: tb/tb_glyph_blitter.sv
// Scoreboard bench for glyph_blitter: an independent pixel model queues the
// expected writes, and every accepted framebuffer write is popped and compared.
module tb_glyph_blitter;

   localparam int FB_W = 160;
   localparam int FB_H = 120;
   localparam int MAXC = 10;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [3:0]        str_len;
   logic [3*MAXC-1:0] char_codes;
   logic [7:0]        org_x;
   logic [6:0]        org_y;
   logic [7:0]        fg_color;
   logic              transparent;
   logic              busy;
   logic              done;
   logic              fb_ready_drv;

   glyph_blitter_if fb_bus ();
   assign fb_bus.fb_ready = fb_ready_drv;

   glyph_blitter #(
      .FB_WIDTH  (FB_W),
      .FB_HEIGHT (FB_H),
      .MAX_CHARS (MAXC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .str_len     (str_len),
      .char_codes  (char_codes),
      .org_x       (org_x),
      .org_y       (org_y),
      .fg_color    (fg_color),
      .transparent (transparent),
      .fb          (fb_bus),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t         sb_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_writes = 0;
   int          n_blank_hits = 0;
   bit          bp_mode = 1'b0;
   bit          bp_used = 1'b0;
   int          stall_edges = 0;
   logic [14:0] hold_addr;
   logic [7:0]  hold_data;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Font bitmaps, all 16 rows per glyph.
   function automatic logic [7:0] font_row(input int code, input int row);
      logic [7:0] r [16];
      case (code)
         0: r = '{8'h00,8'h00,8'h3C,8'h42,8'h40,8'h40,8'h4E,8'h42,8'h42,8'h46,8'h3A,8'h00,8'h00,8'h00,8'h00,8'h00};
         1: r = '{8'h00,8'h00,8'h10,8'h28,8'h44,8'h44,8'h7C,8'h44,8'h44,8'h44,8'h44,8'h00,8'h00,8'h00,8'h00,8'h00};
         2: r = '{8'h00,8'h00,8'h42,8'h66,8'h5A,8'h42,8'h42,8'h42,8'h42,8'h42,8'h42,8'h00,8'h00,8'h00,8'h00,8'h00};
         3: r = '{8'h00,8'h00,8'h7E,8'h40,8'h40,8'h40,8'h7C,8'h40,8'h40,8'h40,8'h7E,8'h00,8'h00,8'h00,8'h00,8'h00};
         4: r = '{8'h00,8'h00,8'h3C,8'h42,8'h42,8'h42,8'h42,8'h42,8'h42,8'h42,8'h3C,8'h00,8'h00,8'h00,8'h00,8'h00};
         5: r = '{8'h00,8'h00,8'h42,8'h42,8'h42,8'h42,8'h42,8'h42,8'h24,8'h24,8'h18,8'h00,8'h00,8'h00,8'h00,8'h00};
         6: r = '{8'h00,8'h00,8'h7C,8'h42,8'h42,8'h42,8'h7C,8'h48,8'h44,8'h42,8'h42,8'h00,8'h00,8'h00,8'h00,8'h00};
         default: r = '{default: 8'h00};
      endcase
      return r[4'(row)];
   endfunction

   function automatic logic [3*MAXC-1:0] pack_codes(input int c [MAXC]);
      logic [3*MAXC-1:0] v;
      v = '0;
      for (int i = 0; i < MAXC; i++) v[5'(3*i) +: 3] = 3'(c[i]);
      return v;
   endfunction

   task automatic build_expect(input int n, input logic [3*MAXC-1:0] codes, input int ox,
                               input int oy, input logic [7:0] fg, input bit tr);
      logic [7:0] bits;
      bit         b;
      int         x;
      int         y;
      wr_t        e;
      for (int i = 0; i < n; i++) begin
         for (int row = 0; row < 16; row++) begin
            bits = font_row(int'(codes[5'(3*i) +: 3]), row);
            for (int col = 0; col < 8; col++) begin
               b = bits[3'(7 - col)];
               x = ox + 8*i + col;
               y = oy + row;
               if (x < FB_W && y < FB_H && (b || !tr)) begin
                  e.addr = 15'(y*FB_W + x);
                  e.data = b ? fg : 8'h00;
                  sb_q.push_back(e);
               end
            end
         end
      end
   endtask

   // Per-negedge observer: drives fb_ready for the backpressure case and
   // scores every write that the following edge will accept.
   task automatic monitor_step();
      wr_t e;
      if (bp_mode && !bp_used) begin
         if (fb_bus.fb_we === 1'b1 && !fb_ready_drv) begin
            if (stall_edges > 0) begin
               check_eq("bp_addr_hold", 32'(fb_bus.fb_addr), 32'(hold_addr));
               check_eq("bp_data_hold", 32'(fb_bus.fb_wdata), 32'(hold_data));
            end
            hold_addr = fb_bus.fb_addr;
            hold_data = fb_bus.fb_wdata;
            if (stall_edges == 3) begin
               fb_ready_drv = 1'b1;
               bp_used      = 1'b1;
            end else begin
               stall_edges++;
            end
         end else if (fb_bus.fb_we !== 1'b1) begin
            fb_ready_drv = 1'b0;
         end
      end else begin
         fb_ready_drv = 1'b1;
      end
      if (fb_bus.fb_we === 1'b1 && fb_ready_drv) begin
         n_writes++;
         if ((int'(fb_bus.fb_addr) % FB_W) >= 40 && (int'(fb_bus.fb_addr) % FB_W) < 48)
            n_blank_hits++;
         if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            check_eq("wr_addr", 32'(fb_bus.fb_addr), 32'(e.addr));
            check_eq("wr_data", 32'(fb_bus.fb_wdata), 32'(e.data));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      monitor_step();
   endtask

   task automatic run_op(input string name, input int n_raw, input logic [3*MAXC-1:0] codes,
                         input int ox, input int oy, input logic [7:0] fg, input bit tr,
                         input bit bp, input bit poke);
      int n;
      int exp_writes;
      int writes_before;
      int k;
      int budget;
      n = (n_raw > MAXC) ? MAXC : n_raw;
      build_expect(n, codes, ox, oy, fg, tr);
      exp_writes    = sb_q.size();
      writes_before = n_writes;
      bp_mode     = bp;
      bp_used     = 1'b0;
      stall_edges = 0;
      budget      = 160*MAXC + 50;
      start       = 1'b1;
      str_len     = 4'(n_raw);
      char_codes  = codes;
      org_x       = 8'(ox);
      org_y       = 7'(oy);
      fg_color    = fg;
      transparent = tr;
      tick();
      // Scramble the inputs: only the values latched at start may matter.
      start       = 1'b0;
      str_len     = 4'($urandom);
      char_codes  = 30'($urandom);
      org_x       = 8'($urandom);
      org_y       = 7'($urandom);
      fg_color    = 8'($urandom);
      transparent = ~tr;
      if (n > 0) check_eq({name, "_busy"}, 32'(busy), 32'd1);
      k = 0;
      while (done !== 1'b1 && k < budget) begin
         start = poke && (k == 20);
         tick();
         k++;
      end
      start = 1'b0;
      check_eq({name, "_done_seen"}, 32'(done), 32'd1);
      check_eq({name, "_latency"}, 32'(k + 1), 32'(160*n + 1 + (bp ? 3 : 0)));
      check_eq({name, "_busy_at_done"}, 32'(busy), 32'd0);
      check_eq({name, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
      check_eq({name, "_write_count"}, 32'(n_writes - writes_before), 32'(exp_writes));
      tick();
      check_eq({name, "_done_pulse"}, 32'(done), 32'd0);
      $display("op %s: len=%0d clamped=%0d writes=%0d latency=%0d", name, n_raw, n,
               n_writes - writes_before, k + 1);
      sb_q.delete();
      bp_mode = 1'b0;
   endtask

   int c_a    [MAXC] = '{1, 7, 7, 7, 7, 7, 7, 7, 7, 7};
   int c_m    [MAXC] = '{2, 7, 7, 7, 7, 7, 7, 7, 7, 7};
   int c_o    [MAXC] = '{4, 7, 7, 7, 7, 7, 7, 7, 7, 7};
   int c_go   [MAXC] = '{0, 1, 2, 3, 7, 4, 5, 3, 6, 7};
   int c_rand [MAXC];

   initial begin
      reset_n      = 1'b0;
      start        = 1'b0;
      str_len      = '0;
      char_codes   = '0;
      org_x        = '0;
      org_y        = '0;
      fg_color     = '0;
      transparent  = 1'b0;
      fb_ready_drv = 1'b1;
      repeat (3) tick();
      check_eq("rst_fb_we", 32'(fb_bus.fb_we), 32'd0);
      check_eq("rst_fb_addr", 32'(fb_bus.fb_addr), 32'd0);
      check_eq("rst_fb_wdata", 32'(fb_bus.fb_wdata), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      tick();

      run_op("single_A", 1, pack_codes(c_a), 0, 0, 8'hA5, 1'b0, 1'b0, 1'b1);

      n_blank_hits = 0;
      run_op("game_over", 9, pack_codes(c_go), 8, 50, 8'h3C, 1'b1, 1'b0, 1'b0);
      check_eq("game_over_blank_x40_47", 32'(n_blank_hits), 32'd0);

      run_op("clip_M", 1, pack_codes(c_m), 156, 118, 8'h77, 1'b0, 1'b0, 1'b0);
      run_op("backpressure", 1, pack_codes(c_a), 20, 30, 8'hC3, 1'b0, 1'b1, 1'b0);
      run_op("len_zero", 0, pack_codes(c_a), 0, 0, 8'hFF, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < MAXC; i++) c_rand[i] = int'($urandom_range(0, 7));
      run_op("len_15", 15, pack_codes(c_rand), 0, 0, 8'h5A, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of row 7 of a single glyph.
      build_expect(1, pack_codes(c_a), 0, 0, 8'hFF, 1'b0);
      start       = 1'b1;
      str_len     = 4'd1;
      char_codes  = pack_codes(c_a);
      org_x       = 8'd0;
      org_y       = 7'd0;
      fg_color    = 8'hFF;
      transparent = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 0; k < 75; k++) tick();
      check_eq("pre_reset_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      tick();
      check_eq("midrst_fb_we", 32'(fb_bus.fb_we), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_done", 32'(done), 32'd0);
      check_eq("midrst_fb_addr", 32'(fb_bus.fb_addr), 32'd0);
      reset_n = 1'b1;
      sb_q.delete();
      tick();
      tick();
      check_eq("post_reset_idle_busy", 32'(busy), 32'd0);
      check_eq("post_reset_idle_we", 32'(fb_bus.fb_we), 32'd0);
      $display("op mid_reset: len=1 aborted in row 7");

      run_op("after_reset_O", 1, pack_codes(c_o), 100, 100, 8'h81, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/glyph_blitter.md
GLYPH_BLITTER -- requirements
Module: glyph_blitter

Interface
REQ-001 SHALL have parameters: FB_WIDTH, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameters: FB_HEIGHT, default 120, framebuffer height in pixels.
REQ-003 SHALL have parameter MAX_CHARS, default 10, the longest string in characters.
REQ-004 Clk  input  1  single clock; all logic on its rising edge.
REQ-005 Reset_n  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 str_len  input  4  number of characters to draw.
REQ-008 char_codes  input  3*MAX_CHARS  glyph codes; char i at bits [3i+2:3i]; char 0 leftmost.
REQ-009 org_x  input  8  top-left X of the string; org_y  input  7  top-left Y of the string.
REQ-010 fg_color  input  8  colour for set glyph bits; transparent  input  1  1 = skip clear bits.
REQ-011 fb_addr  output  15  framebuffer write address = y*FB_WIDTH + x.
REQ-012 fb_wdata  output  8  write data; fb_we  output  1  write request; fb_ready  input  1  write accepted.
REQ-013 busy  output  1  operation in progress; done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL latch str_len, char_codes, org_x, org_y, fg_color and transparent on the edge that accepts start; later input changes SHALL have no effect until done.
REQ-015 SHALL clamp a latched str_len greater than MAX_CHARS to MAX_CHARS.
REQ-016 FSM states SHALL be IDLE, FETCH, WAIT, WRITE and DONE.
REQ-017 IDLE->FETCH on start; IDLE->DONE if start arrives with str_len=0.
REQ-018 FETCH issues glyph ROM address {code,row}; WAIT covers the 1-cycle ROM latency.
REQ-019 WRITE SHALL spend one pixel slot per column, col 0..7; the pixel bit is slice[7-col] (MSB leftmost).
REQ-020 After col 7, WRITE->FETCH with the next row; after row 15, the next char at row 0; after the last char, WRITE->DONE.
REQ-021 DONE->IDLE unconditionally; done=1 only in DONE; busy=1 in FETCH, WAIT and WRITE only.
REQ-022 Pixel coordinates: x = org_x + 8*char_idx + col and y = org_y + row, computed without truncation (>=10 bits).
REQ-023 fb_we=1 in a WRITE slot only if x<FB_WIDTH, y<FB_HEIGHT, and (bit=1 or transparent=0). Otherwise the slot takes one cycle with fb_we=0 (clipping, no wrap).
REQ-024 fb_wdata SHALL be fg_color when the bit is 1, and 8'h00 when the bit is 0 with transparent=0.
REQ-025 While fb_we=1 and fb_ready=0, the block SHALL stall holding fb_addr/fb_wdata/fb_we stable; a slot advances on fb_we&fb_ready or when fb_we=0.
REQ-026 With fb_ready tied 1, latency from the start edge to the done cycle SHALL be 160*N+1 cycles (N = clamped length): 10 cycles per row, 16 rows per char.
REQ-027 start while not IDLE SHALL be ignored.

Reset
REQ-028 Reset_n=0 at an edge SHALL force IDLE from any state, including mid-string.
REQ-029 Reset values: fb_we=0, busy=0, done=0, fb_addr=0, fb_wdata=0, all counters 0; no partial write after reset.

Structure
REQ-030 Shared package glyph_pkg SHALL hold glyph codes (G=0, A=1, M=2, E=3, O=4, V=5, R=6, BLANK=7), GLYPH_W=8, GLYPH_H=16 and the FSM state enum.
REQ-031 One sub-module glyph_rom SHALL provide 128x8 entries, a registered read (1-cycle latency) and address {code[2:0],row[3:0]}. BLANK rows SHALL be all-zero, with 16 rows per glyph and rows 0,1,12-15 blank.

Verification
REQ-032 Single glyph: start, str_len=1, code A, org (0,0), transparent=0, fb_ready=1 -> 128 writes, addr 0..7,160..167,...; row 2 data {0,0,0,FG,0,0,0,0}; done at cycle 161.
REQ-033 "GAME OVER" (9 chars, BLANK at idx 4), transparent=1, org (8,50) -> writes only at set bits; no write in x 40..47; done at cycle 1441.
REQ-034 Clipping: org (156,118), str_len=1, code M -> writes only for x in 156..159 and y in 118..119; none wrap to row 0 or to the next line.
REQ-035 Backpressure: fb_ready low 3 cycles on the first write -> fb_addr/fb_wdata held stable; total latency grows by exactly 3.
REQ-036 Edges: str_len=0 -> done next cycle, zero writes. str_len=15 -> treated as 10. Reset_n low mid-row 7 -> IDLE next edge, fb_we=0, busy=0. start while busy -> ignored.
